// File: rtl/scariv_conf_pkg.sv
// rtl/scariv_conf_pkg.sv - core-wide configuration constants for the L1D miss path
package scariv_conf_pkg;

  localparam int MSHR_N = 4;

endpackage : scariv_conf_pkg

// File: rtl/scariv_lsu_pkg.sv
// rtl/scariv_lsu_pkg.sv - LSU-side MSHR types and helpers shared by the MSHR scheduler
package scariv_lsu_pkg;

  localparam int MSHR_N = scariv_conf_pkg::MSHR_N;
  localparam int IDX_W  = $clog2(MSHR_N);
  localparam int CNT_W  = IDX_W + 1;

  typedef logic [IDX_W-1:0] mshr_idx_t;
  typedef logic [CNT_W-1:0] mshr_cnt_t;

  // Pointer increment; MSHR_N is a power of two so the wrap is the natural overflow.
  function automatic mshr_idx_t mshr_idx_inc(mshr_idx_t idx);
    return idx + mshr_idx_t'(1);
  endfunction

endpackage : scariv_lsu_pkg

// File: rtl/scariv_l1d_mshr_rr_arb.sv
// rtl/scariv_l1d_mshr_rr_arb.sv - request/ready arbiter with grant lock; SCARIV_L1D_MSHR_RR_ARB_EN selects round-robin, else fixed lowest-index priority
module scariv_l1d_mshr_rr_arb #(
  parameter int WIDTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [WIDTH-1:0]         i_req,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [$clog2(WIDTH)-1:0] o_grant_idx,
  output logic [WIDTH-1:0]         o_accept
);

  localparam int IDX_W = $clog2(WIDTH);

  logic             r_locked;
  logic [IDX_W-1:0] r_lock_idx;
  logic [IDX_W-1:0] pick_idx;
  logic             lock_hit;
  logic             fire;

`ifdef SCARIV_L1D_MSHR_RR_ARB_EN
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Round-robin search: first requester at or after the priority pointer, wrapping.
  always_comb begin
    pick_idx = r_ptr;
    cand     = r_ptr;
    found    = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      cand = r_ptr + IDX_W'(i);
      if (!found && i_req[cand]) begin
        pick_idx = cand;
        found    = 1'b1;
      end
    end
  end

  // Priority pointer moves just past the winner on every accepted handshake.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ptr <= '0;
    end else if (fire) begin
      r_ptr <= o_grant_idx + IDX_W'(1);
    end
  end
`else
  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    pick_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_req[i]) pick_idx = IDX_W'(i);
    end
  end
`endif

  assign lock_hit    = r_locked & i_req[r_lock_idx];
  assign o_grant_idx = lock_hit ? r_lock_idx : pick_idx;
  // Reset forces the port idle at once so no handshake can be seen while in reset.
  assign o_valid     = i_reset_n & (|i_req);
  assign fire        = o_valid & i_ready;

  // One-hot accept pulse toward the granted entry.
  always_comb begin
    o_accept              = '0;
    o_accept[o_grant_idx] = fire;
  end

  // A stalled grant is remembered so a newly arriving request cannot steal the port.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      r_locked   <= o_valid & ~i_ready;
      r_lock_idx <= o_grant_idx;
    end
  end

endmodule : scariv_l1d_mshr_rr_arb

// File: rtl/scariv_l1d_mshr_sched.sv
// rtl/scariv_l1d_mshr_sched.sv - in-order MSHR allocate/retire plus refill/write/evict port arbitration; SCARIV_L1D_MSHR_RR_ARB_EN selects round-robin arbiters
module scariv_l1d_mshr_sched
  import scariv_lsu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset_n,

  input  logic              i_alloc_req,
  output logic              o_alloc_ready,
  output logic [IDX_W-1:0]  o_alloc_index,
  output logic [MSHR_N-1:0] o_entry_load,

  input  logic [MSHR_N-1:0] i_ext_req_ready,
  output logic              o_l2_req_valid,
  output logic [IDX_W-1:0]  o_l2_req_index,
  input  logic              i_l2_req_ready,
  output logic [MSHR_N-1:0] o_entry_sent,

  input  logic [MSHR_N-1:0] i_wr_req_valid,
  output logic              o_l1d_wr_valid,
  output logic [IDX_W-1:0]  o_l1d_wr_index,
  input  logic              i_l1d_wr_ready,
  output logic [MSHR_N-1:0] o_wr_accepted,

  input  logic [MSHR_N-1:0] i_evict_ready,
  output logic              o_evict_valid,
  output logic [IDX_W-1:0]  o_evict_index,
  input  logic              i_evict_port_ready,
  output logic [MSHR_N-1:0] o_evict_sent,

  input  logic [MSHR_N-1:0] i_entry_finish,
  output logic [MSHR_N-1:0] o_out_ptr_valid,
  output logic              o_full,
  output logic [CNT_W-1:0]  o_count
);

  mshr_idx_t         r_in_ptr;
  mshr_idx_t         r_out_ptr;
  mshr_cnt_t         r_count;
  logic              alloc_fire;
  logic              finish_fire;
  logic [MSHR_N-1:0] out_sel;

  assign o_full        = (r_count == CNT_W'(MSHR_N));
  assign o_alloc_ready = ~o_full;
  assign o_alloc_index = r_in_ptr;
  assign o_count       = r_count;
  assign alloc_fire    = i_reset_n & i_alloc_req & o_alloc_ready;
  assign finish_fire   = i_entry_finish[r_out_ptr];

  // Decode the in/out pointers into the per-entry load strobe and oldest marker.
  always_comb begin
    o_entry_load           = '0;
    o_entry_load[r_in_ptr] = alloc_fire;
    out_sel                = '0;
    out_sel[r_out_ptr]     = 1'b1;
    o_out_ptr_valid        = (r_count != '0) ? out_sel : '0;
  end

  // Pointers and occupancy; simultaneous allocate and finish cancel in the count.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_in_ptr  <= '0;
      r_out_ptr <= '0;
      r_count   <= '0;
    end else begin
      if (alloc_fire)  r_in_ptr  <= mshr_idx_inc(r_in_ptr);
      if (finish_fire) r_out_ptr <= mshr_idx_inc(r_out_ptr);
      case ({alloc_fire, finish_fire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  scariv_l1d_mshr_rr_arb #(.WIDTH(MSHR_N)) u_refill_arb (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_req       (i_ext_req_ready),
    .i_ready     (i_l2_req_ready),
    .o_valid     (o_l2_req_valid),
    .o_grant_idx (o_l2_req_index),
    .o_accept    (o_entry_sent)
  );

  scariv_l1d_mshr_rr_arb #(.WIDTH(MSHR_N)) u_write_arb (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_req       (i_wr_req_valid),
    .i_ready     (i_l1d_wr_ready),
    .o_valid     (o_l1d_wr_valid),
    .o_grant_idx (o_l1d_wr_index),
    .o_accept    (o_wr_accepted)
  );

  scariv_l1d_mshr_rr_arb #(.WIDTH(MSHR_N)) u_evict_arb (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_req       (i_evict_ready),
    .i_ready     (i_evict_port_ready),
    .o_valid     (o_evict_valid),
    .o_grant_idx (o_evict_index),
    .o_accept    (o_evict_sent)
  );

`ifdef SIMULATION
  // Retirement protocol: single finish, oldest entry only, no count wrap.
  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      if ($countones(i_entry_finish) > 1)
        $fatal(1, "mshr_sched: multiple finish bits %b", i_entry_finish);
      if (|(i_entry_finish & ~out_sel))
        $fatal(1, "mshr_sched: finish %b not at out pointer %0d", i_entry_finish, r_out_ptr);
      if (finish_fire && !alloc_fire && (r_count == '0))
        $fatal(1, "mshr_sched: occupancy underflow");
      if (alloc_fire && !finish_fire && o_full)
        $fatal(1, "mshr_sched: occupancy overflow");
    end
  end
`endif

endmodule : scariv_l1d_mshr_sched

// File: tb/tb_scariv_l1d_mshr_sched.sv
// tb/tb_scariv_l1d_mshr_sched.sv - self-checking bench for the MSHR scheduler with a queue-based reference model
module tb_scariv_l1d_mshr_sched;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         alloc_req = 1'b0;
  logic         alloc_ready;
  logic [1:0]   alloc_index;
  logic [N-1:0] entry_load;
  logic [N-1:0] ext_req = '0;
  logic         l2_valid;
  logic [1:0]   l2_index;
  logic         l2_ready = 1'b0;
  logic [N-1:0] entry_sent;
  logic [N-1:0] wr_req = '0;
  logic         wr_valid;
  logic [1:0]   wr_index;
  logic         wr_ready = 1'b0;
  logic [N-1:0] wr_acc;
  logic [N-1:0] ev_req = '0;
  logic         ev_valid;
  logic [1:0]   ev_index;
  logic         ev_ready = 1'b0;
  logic [N-1:0] ev_sent;
  logic [N-1:0] fin = '0;
  logic [N-1:0] out_ptr_valid;
  logic         full;
  logic [2:0]   count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  scariv_l1d_mshr_sched dut (
    .i_clk              (clk),
    .i_reset_n          (rst_n),
    .i_alloc_req        (alloc_req),
    .o_alloc_ready      (alloc_ready),
    .o_alloc_index      (alloc_index),
    .o_entry_load       (entry_load),
    .i_ext_req_ready    (ext_req),
    .o_l2_req_valid     (l2_valid),
    .o_l2_req_index     (l2_index),
    .i_l2_req_ready     (l2_ready),
    .o_entry_sent       (entry_sent),
    .i_wr_req_valid     (wr_req),
    .o_l1d_wr_valid     (wr_valid),
    .o_l1d_wr_index     (wr_index),
    .i_l1d_wr_ready     (wr_ready),
    .o_wr_accepted      (wr_acc),
    .i_evict_ready      (ev_req),
    .o_evict_valid      (ev_valid),
    .o_evict_index      (ev_index),
    .i_evict_port_ready (ev_ready),
    .o_evict_sent       (ev_sent),
    .i_entry_finish     (fin),
    .o_out_ptr_valid    (out_ptr_valid),
    .o_full             (full),
    .o_count            (count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: live entries as an ordered queue of indices, per-port lock/priority.
  int m_q[$];
  int m_in = 0;
  int m_ptr[3] = '{0, 0, 0};
  bit m_hold[3] = '{0, 0, 0};
  int m_hold_idx[3] = '{0, 0, 0};
  string port_nm[3] = '{"refill", "write", "evict"};

  function automatic logic [N-1:0] req_of(int a);
    case (a)
      0:       return ext_req;
      1:       return wr_req;
      default: return ev_req;
    endcase
  endfunction

  function automatic logic rdy_of(int a);
    case (a)
      0:       return l2_ready;
      1:       return wr_ready;
      default: return ev_ready;
    endcase
  endfunction

  function automatic logic valid_of(int a);
    case (a)
      0:       return l2_valid;
      1:       return wr_valid;
      default: return ev_valid;
    endcase
  endfunction

  function automatic logic [1:0] idx_of(int a);
    case (a)
      0:       return l2_index;
      1:       return wr_index;
      default: return ev_index;
    endcase
  endfunction

  function automatic logic [N-1:0] pulse_of(int a);
    case (a)
      0:       return entry_sent;
      1:       return wr_acc;
      default: return ev_sent;
    endcase
  endfunction

  // Which entry the port serves now, or -1 when the port is idle.
  function automatic int pick(int a);
    logic [N-1:0] r;
    int start;
    r = req_of(a);
    if (!rst_n || r == '0) return -1;
    if (m_hold[a] && r[m_hold_idx[a]]) return m_hold_idx[a];
`ifdef SCARIV_L1D_MSHR_RR_ARB_EN
    start = m_ptr[a];
`else
    start = 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_in = 0;
    for (int a = 0; a < 3; a++) begin
      m_ptr[a]  = 0;
      m_hold[a] = 1'b0;
    end
  endtask

  task automatic model_compare();
    int g;
    logic [N-1:0] exp_load;
    logic [N-1:0] exp_out;
    exp_load = (rst_n && alloc_req && m_q.size() != N) ? N'(1 << m_in) : '0;
    exp_out  = (m_q.size() != 0) ? N'(1 << m_q[0]) : '0;
    chk("alloc_ready", alloc_ready, m_q.size() != N);
    chk("alloc_index", alloc_index, m_in);
    chk("entry_load", entry_load, exp_load);
    chk("out_ptr_valid", out_ptr_valid, exp_out);
    chk("full", full, m_q.size() == N);
    chk("count", count, m_q.size());
    for (int a = 0; a < 3; a++) begin
      g = pick(a);
      chk({port_nm[a], "_valid"}, valid_of(a), g >= 0);
      if (g >= 0) chk({port_nm[a], "_index"}, idx_of(a), g);
      chk({port_nm[a], "_pulse"}, pulse_of(a), (g >= 0 && rdy_of(a)) ? (1 << g) : 0);
    end
  endtask

  task automatic model_step();
    int g;
    bit do_alloc;
    for (int a = 0; a < 3; a++) begin
      g = pick(a);
      if (g >= 0 && rdy_of(a)) begin
        m_ptr[a]  = (g + 1) % N;
        m_hold[a] = 1'b0;
      end else if (g >= 0) begin
        m_hold[a]     = 1'b1;
        m_hold_idx[a] = g;
      end else begin
        m_hold[a] = 1'b0;
      end
    end
    do_alloc = alloc_req && (m_q.size() != N);
    if (m_q.size() != 0 && fin[m_q[0]]) void'(m_q.pop_front());
    if (do_alloc) begin
      m_q.push_back(m_in);
      m_in = (m_in + 1) % N;
    end
  endtask

  // Inputs only change just after posedge, so the negedge view equals what the next edge samples.
  always @(negedge clk) begin : model_cmp
    if (!rst_n) model_reset();
    model_compare();
    if (rst_n) model_step();
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int exp_idx;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_index", alloc_index, 0);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_out_ptr", out_ptr_valid, 0);

    // Four back-to-back allocations fill the array.
    next_cycle();
    rst_n = 1'b1;
    alloc_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("alloc_load_seq", entry_load, 1 << k);
      next_cycle();
    end
    @(negedge clk);
    chk("full_flag", full, 1);
    chk("full_ready", alloc_ready, 0);
    chk("full_no_load", entry_load, 0);
    chk("full_count", count, 4);

    // Finish entry 0 at full while allocation keeps being requested.
    next_cycle();
    fin = 4'b0001;
    @(negedge clk);
    chk("fin_at_full_no_load", entry_load, 0);
    chk("fin_at_full_out", out_ptr_valid, 4'b0001);
    next_cycle();
    fin = '0;
    @(negedge clk);
    chk("realloc_idx0", entry_load, 4'b0001);
    chk("out_moved", out_ptr_valid, 4'b0010);
    next_cycle();
    alloc_req = 1'b0;
    @(negedge clk);
    chk("refull_count", count, 4);
    chk("refull_out", out_ptr_valid, 4'b0010);

    // Drain in order 1,2,3,0.
    next_cycle();
    for (int k = 1; k <= 4; k++) begin
      fin = 4'(1 << (k % 4));
      next_cycle();
    end
    fin = '0;
    @(negedge clk);
    chk("drained_count", count, 0);
    chk("drained_out", out_ptr_valid, 0);

    // Allocate and finish together at occupancy one.
    next_cycle();
    alloc_req = 1'b1;
    next_cycle();
    fin = 4'b0010;
    @(negedge clk);
    chk("af_load", entry_load, 4'b0100);
    chk("af_out", out_ptr_valid, 4'b0010);
    next_cycle();
    alloc_req = 1'b0;
    fin = '0;
    @(negedge clk);
    chk("af_count", count, 1);
    chk("af_out_next", out_ptr_valid, 4'b0100);
    next_cycle();
    fin = 4'b0100;
    next_cycle();
    fin = '0;

    // Refill port with all entries requesting and L2 always ready.
    ext_req = 4'b1111;
    l2_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
`ifdef SCARIV_L1D_MSHR_RR_ARB_EN
      exp_idx = k % 4;
`else
      exp_idx = 0;
`endif
      chk("refill_seq_idx", l2_index, exp_idx);
      chk("refill_seq_sent", entry_sent, 1 << exp_idx);
      next_cycle();
    end
    ext_req = '0;
    l2_ready = 1'b0;

    // Write port lock: index 2 stalls, then index 0 appears.
    wr_req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wr_stall_idx", wr_index, 2);
      chk("wr_stall_acc", wr_acc, 0);
      next_cycle();
    end
    wr_req = 4'b0101;
    @(negedge clk);
    chk("wr_lock_idx", wr_index, 2);
    next_cycle();
    wr_ready = 1'b1;
    @(negedge clk);
    chk("wr_lock_acc", wr_acc, 4'b0100);
    next_cycle();
    wr_req = 4'b0001;
    @(negedge clk);
    chk("wr_next_idx", wr_index, 0);
    chk("wr_next_acc", wr_acc, 4'b0001);
    next_cycle();
    wr_req = '0;
    wr_ready = 1'b0;

    // Refill and evict for different entries in the same cycle.
    ext_req = 4'b0010;
    ev_req = 4'b1000;
    l2_ready = 1'b1;
    ev_ready = 1'b1;
    @(negedge clk);
    chk("dual_sent", entry_sent, 4'b0010);
    chk("dual_evict", ev_sent, 4'b1000);
    next_cycle();
    ext_req = '0;
    ev_req = '0;
    l2_ready = 1'b0;
    ev_ready = 1'b0;

    // Reset while an eviction is pending.
    alloc_req = 1'b1;
    next_cycle();
    alloc_req = 1'b0;
    ev_req = 4'b0100;
    @(negedge clk);
    chk("pre_rst_ev_valid", ev_valid, 1);
    chk("pre_rst_count", count, 1);
    #2;
    rst_n = 1'b0;
    ev_ready = 1'b1;
    #1;
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_sent", ev_sent, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_out", out_ptr_valid, 0);
    chk("rst_mid_ready", alloc_ready, 1);
    chk("rst_mid_full", full, 0);
    next_cycle();
    ev_req = '0;
    ev_ready = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    repeat (3) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_scariv_l1d_mshr_sched
